// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampled UART receiver with a 2-flop rx synchroniser.
// Define UART_RX_PARITY_EN to add a parity bit after the data (PAR_ODD picks odd).
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PAR_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            framing_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic            parity_err
`endif
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            pe_q, pe_d;
`endif
  logic            rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    fe_d    = fe_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(7)) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(15)) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[DBIT-1:1]};
            if (n_cnt_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(15)) begin
            s_cnt_d = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == SW'(SB_TICK - 1)) begin
            done_d  = 1'b1;
            dout_d  = b_q;
            fe_d    = ~rx_s;
`ifdef UART_RX_PARITY_EN
            pe_d    = ((^b_q) ^ par_q) != PAR_ODD;
`endif
            s_cnt_d = '0;
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign framing_err  = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = pe_q;
`endif

endmodule
